// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encoding and default cycle constants for the PLL lock sequencer.
// Defaults target the fomu board running from its 48 MHz reference clock.
package pll_lock_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES         = 2;
  localparam int unsigned DEF_PLL_RESET_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 4096;
  localparam int unsigned DEF_MAX_RETRIES         = 3;
  localparam int unsigned DEF_CNT_W               = 17;
  localparam int unsigned DEF_LOSS_W              = 8;

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// Single-bit synchroniser: STAGES flops in a chain, all asynchronously cleared.
// STAGES must be at least 2.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Supervises a PLL: pulses its RESETB, qualifies LOCK, retries on timeout and
// holds downstream logic in reset until lock has been stable long enough.
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int unsigned PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W,
  parameter int unsigned LOSS_W              = DEF_LOSS_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              locked,
  input  logic              retry,
  output logic              pll_resetb,
  output logic              out_reset,
  output logic              ready,
  output logic              fail,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [RETRY_W-1:0]  retries, retries_n;
  logic                lock_s;
  logic                pll_resetb_n, out_reset_n, ready_n, fail_n, lock_lost_n;
  logic [LOSS_W-1:0]   loss_count_n;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked),
    .q     (lock_s)
  );

  // State, counters and outputs all update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_PLL_RST;
      cnt        <= '0;
      retries    <= '0;
      pll_resetb <= 1'b0;
      out_reset  <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retries    <= retries_n;
      pll_resetb <= pll_resetb_n;
      out_reset  <= out_reset_n;
      ready      <= ready_n;
      fail       <= fail_n;
      lock_lost  <= lock_lost_n;
      loss_count <= loss_count_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    retries_n    = retries;
    lock_lost_n  = lock_lost;
    loss_count_n = loss_count;

    case (state)
      ST_PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_n = ST_STABLE;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_n = '0;
          if (retries == RETRY_LAST) begin
            state_n = ST_FAIL;
          end else begin
            state_n   = ST_PLL_RST;
            retries_n = retries + RETRY_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // Any synchronised low restarts the lock timeout, not the PLL.
        if (!lock_s) begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_n     = ST_WAIT_LOCK;
          cnt_n       = '0;
          lock_lost_n = 1'b1;
          if (loss_count != '1) loss_count_n = loss_count + LOSS_W'(1);
        end
      end
      ST_FAIL: begin
        if (retry) begin
          state_n   = ST_PLL_RST;
          cnt_n     = '0;
          retries_n = '0;
        end
      end
      default: begin
        state_n = ST_PLL_RST;
        cnt_n   = '0;
      end
    endcase

    if (state_n == ST_RUN) retries_n = '0;

    // Outputs are decoded from the next state so they are valid on entry.
    pll_resetb_n = !((state_n == ST_PLL_RST) || (state_n == ST_FAIL));
    out_reset_n  = (state_n != ST_RUN);
    ready_n      = (state_n == ST_RUN);
    fail_n       = (state_n == ST_FAIL);
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short test timing parameters.
// Expected cycle counts are hand-derived from the state machine description.
module tb_pll_lock_sequencer;

  logic       clock;
  logic       reset;
  logic       locked;
  logic       retry;
  logic       pll_resetb;
  logic       out_reset;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [7:0] loss_count;

  int checks;
  int failures;

  pll_lock_sequencer #(
    .SYNC_STAGES         (2),
    .PLL_RESET_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .CNT_W               (17),
    .LOSS_W              (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .locked     (locked),
    .retry      (retry),
    .pll_resetb (pll_resetb),
    .out_reset  (out_reset),
    .ready      (ready),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .loss_count (loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    while (!ready && n < max) begin
      step(1);
      n++;
    end
  endtask

  task automatic measure(input logic lvl, input int max, output int n);
    n = 0;
    while (pll_resetb === lvl && n < max) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n;
    logic any_low;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    locked   = 1'b1;
    retry    = 1'b0;

    // Reset values
    #2;
    chk("rst_pll_resetb", 32'(pll_resetb), 32'd0);
    chk("rst_out_reset",  32'(out_reset),  32'd1);
    chk("rst_ready",      32'(ready),      32'd0);
    chk("rst_fail",       32'(fail),       32'd0);
    chk("rst_lock_lost",  32'(lock_lost),  32'd0);
    chk("rst_loss_count", 32'(loss_count), 32'd0);

    // Lock already high: 4 cycles of PLL reset, RUN 13 edges after release
    step(2);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      chk("pllrst_low", 32'(pll_resetb), 32'd0);
    end
    step(1);
    chk("pllrst_release", 32'(pll_resetb), 32'd1);
    chk("wait_out_reset", 32'(out_reset), 32'd1);
    wait_ready(40, n);
    chk("run_latency", 32'(n + 4), 32'd13);
    chk("run_out_reset", 32'(out_reset), 32'd0);
    chk("run_fail", 32'(fail), 32'd0);

    // Retry outside FAIL is ignored
    retry = 1'b1;
    step(1);
    retry = 1'b0;
    chk("retry_in_run_ready", 32'(ready), 32'd1);
    chk("retry_in_run_pll", 32'(pll_resetb), 32'd1);
    step(3);
    chk("retry_in_run_later", 32'(ready), 32'd1);

    // Two lock losses in RUN, 10 cycles each
    for (int k = 1; k <= 2; k++) begin
      locked = 1'b0;
      step(2);
      chk("loss_sync_delay", 32'(out_reset), 32'd0);
      step(1);
      chk("loss_out_reset", 32'(out_reset), 32'd1);
      chk("loss_ready", 32'(ready), 32'd0);
      chk("loss_lock_lost", 32'(lock_lost), 32'd1);
      chk("loss_count", 32'(loss_count), 32'(k));
      chk("loss_pll_kept", 32'(pll_resetb), 32'd1);
      step(7);
      locked = 1'b1;
      wait_ready(40, n);
      chk("requal_ready", 32'(ready), 32'd1);
      chk("requal_out_reset", 32'(out_reset), 32'd0);
    end
    chk("lock_lost_sticky", 32'(lock_lost), 32'd1);
    chk("loss_count_final", 32'(loss_count), 32'd2);

    // Async reset mid-RUN, no clock edge needed
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("async_run_pll", 32'(pll_resetb), 32'd0);
    chk("async_run_out_reset", 32'(out_reset), 32'd1);
    chk("async_run_loss_count", 32'(loss_count), 32'd0);
    chk("async_run_lock_lost", 32'(lock_lost), 32'd0);
    chk("async_run_ready", 32'(ready), 32'd0);

    // No lock: three PLL reset pulses, then FAIL
    locked = 1'b0;
    step(2);
    reset = 1'b0;
    for (int p = 0; p < 3; p++) begin
      measure(1'b0, 20, n);
      chk("nolock_low_len", 32'(n), 32'd4);
      measure(1'b1, 60, n);
      chk("nolock_wait_len", 32'(n), 32'd32);
    end
    chk("fail_set", 32'(fail), 32'd1);
    chk("fail_pll", 32'(pll_resetb), 32'd0);
    step(50);
    chk("fail_hold", 32'(fail), 32'd1);
    chk("fail_hold_pll", 32'(pll_resetb), 32'd0);
    chk("fail_hold_out_reset", 32'(out_reset), 32'd1);
    chk("fail_hold_ready", 32'(ready), 32'd0);

    // Lock returns, retry from FAIL: RUN 14 edges after the retry edge
    locked = 1'b1;
    step(3);
    chk("fail_ignores_lock", 32'(fail), 32'd1);
    retry = 1'b1;
    step(1);
    retry = 1'b0;
    chk("retry_fail_clear", 32'(fail), 32'd0);
    chk("retry_pll_rst", 32'(pll_resetb), 32'd0);
    wait_ready(40, n);
    chk("retry_latency", 32'(n + 1), 32'd14);

    // Lock glitch at STABLE cycle 5 restarts qualification
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(10);
    chk("stable_pre_glitch", 32'(out_reset), 32'd1);
    locked  = 1'b0;
    any_low = 1'b0;
    for (int i = 11; i <= 25; i++) begin
      step(1);
      if (out_reset !== 1'b1) any_low = 1'b1;
      if (i == 15) locked = 1'b1;
    end
    chk("glitch_out_reset_held", 32'(any_low), 32'd0);
    step(1);
    chk("glitch_requal_ready", 32'(ready), 32'd1);

    // Async reset mid-STABLE
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(8);
    chk("stable_pll_up", 32'(pll_resetb), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_stable_pll", 32'(pll_resetb), 32'd0);
    chk("async_stable_out_reset", 32'(out_reset), 32'd1);
    chk("async_stable_loss_count", 32'(loss_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Supervises an iCE40 SB_PLL40_CORE wrapper. Drives the PLL's RESETB, watches its asynchronous `locked` output, and holds downstream logic in reset until lock has been stable for a programmable time.
- Retries the PLL on lock timeout and reasserts downstream reset on lock loss.
- Runs on the board reference clock (e.g. 48 MHz), never on the PLL output. Downstream domains re-synchronise `out_reset` themselves.

Parameters:
- SYNC_STAGES, 2, flops in the `locked` synchroniser (≥2)
- PLL_RESET_CYCLES, 16, cycles pll_resetb is held low per reset attempt (≥1)
- LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before a retry (≥2)
- LOCK_STABLE_CYCLES, 4096, consecutive synchronised-lock cycles required before release (≥1)
- MAX_RETRIES, 3, PLL reset retries after the first attempt before FAIL
- CNT_W, 17, shared counter width; must hold max(all cycle params)
- LOSS_W, 8, width of lock-loss counter

Ports:
- clock  in  1  reference clock; all state on its rising edge
- reset  in  1  asynchronous, active-high; asserted → all regs to reset values immediately
- locked  in  1  PLL LOCK, asynchronous to clock
- retry  in  1  single-cycle request; leaves FAIL only
- pll_resetb  out  1  to PLL RESETB, active-low
- out_reset  out  1  active-high reset for downstream logic
- ready  out  1  high only in RUN
- fail  out  1  high only in FAIL
- lock_lost  out  1  sticky: lock dropped while in RUN; cleared only by reset
- loss_count  out  LOSS_W  saturating count of RUN→lock-loss events

Behaviour:
- Reset values:
  - state=PLL_RST, cnt=0, retries=0, sync chain=0
  - pll_resetb=0, out_reset=1, ready=0, fail=0, lock_lost=0, loss_count=0
- Sync: lock_s = last flop of the SYNC_STAGES chain. Only lock_s is used internally.
- All outputs are registers, written on the same edge as the state change. The value in a state's first cycle is already the state's value.
- States:
  - PLL_RST:
    - pll_resetb=0, out_reset=1.
    - cnt increments each cycle. At cnt==PLL_RESET_CYCLES-1: → WAIT_LOCK, cnt=0.
  - WAIT_LOCK:
    - pll_resetb=1, out_reset=1.
    - If lock_s: → STABLE, cnt=0.
    - Else if cnt==LOCK_TIMEOUT_CYCLES-1:
      - retries==MAX_RETRIES → FAIL.
      - Otherwise retries+1 → PLL_RST, cnt=0.
    - Else cnt+1.
  - STABLE:
    - pll_resetb=1, out_reset=1.
    - If !lock_s: → WAIT_LOCK, cnt=0. Timeout restarts; retries unchanged.
    - Else if cnt==LOCK_STABLE_CYCLES-1: → RUN.
    - Else cnt+1.
  - RUN:
    - pll_resetb=1, out_reset=0, ready=1. retries is cleared on entry.
    - If !lock_s: → WAIT_LOCK, cnt=0; lock_lost=1; loss_count+1, saturating at all-ones.
  - FAIL:
    - pll_resetb=0 (PLL parked), out_reset=1, fail=1.
    - retry==1: → PLL_RST, cnt=0, retries=0.
- retry is ignored in every state other than FAIL.
- Latency, lock already high after the first PLL_RST: RUN is reached PLL_RESET_CYCLES + SYNC_STAGES + LOCK_STABLE_CYCLES cycles (±1) after reset release. Exact count is checked in test.
- Glitches on `locked` shorter than one cycle may be missed. Any lock_s low in STABLE restarts qualification.
- Async reset mid-operation → immediate reset values, including a PLL re-reset.
- Counter comparisons use CNT_W unsigned; no wrap occurs given the parameter constraints.

Decomposition:
- Shared include/package:
  - state encoding localparams ST_PLL_RST, ST_WAIT_LOCK, ST_STABLE, ST_RUN, ST_FAIL (3-bit binary)
  - default cycle constants per board (fomu 48 MHz)
- One sub-module, `sync_bit`: parameter STAGES, async-reset-to-0 flop chain, single-bit. Reusable elsewhere.

Test Plan:
(Test parameters: PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.)
- locked tied 1, release reset → pll_resetb low 4 cycles; out_reset falls and ready rises 14 (±1) cycles after reset release; fail=0.
- locked tied 0 → 3 PLL_RST pulses, each 4 cycles low, spaced by 32-cycle WAIT_LOCK. Then fail=1, pll_resetb=0, out_reset=1 indefinitely.
- In FAIL, set locked=1 and pulse retry → PLL_RST; RUN ~14 cycles later; fail=0. A retry pulse while in RUN has no effect.
- locked drops for 5 cycles at cycle 5 of STABLE → returns to WAIT_LOCK; out_reset never deasserts; RUN only after 8 fresh consecutive lock cycles.
- In RUN, drop locked for 10 cycles, twice → out_reset reasserts within 3 cycles each time; lock_lost=1, loss_count=2, ready returns after requalification.
- Assert reset asynchronously mid-STABLE and mid-RUN → pll_resetb=0, out_reset=1, loss_count=0 without waiting for a clock edge.
